dpram_bist: RTL and testbench

DPRAM_BIST -- requirements
Module: dpram_bist

---
 rtl/dpram_bist_pkg.sv | 31 +++
 rtl/dpram_bist_checker.sv | 80 ++++++++
 rtl/dpram_bist.sv | 201 ++++++++++++++++++++
 tb/tb_dpram_bist.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_bist_pkg.sv
// Shared types and constants for the dual-port RAM march-style BIST.
// Phase lengths are given for the default depth; the top derives them for other widths.
package dpram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_RD_B,
        ST_RD_A,
        ST_DONE
    } state_t;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 6;

    localparam int unsigned WR_A_LEN = 64;
    localparam int unsigned RD_B_LEN = 65;
    localparam int unsigned RD_A_LEN = 65;

    localparam int unsigned ERR_MAX = 128;

    function automatic int unsigned wr_len(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Read phases run one extra cycle to collect the last registered RAM word.
    function automatic int unsigned rd_len(input int unsigned aw);
        return (32'd1 << aw) + 32'd1;
    endfunction

endpackage

// File: rtl/dpram_bist_checker.sv
// Compare pipeline for RAM read data: aligns expected values with the
// one-clock RAM latency, counts mismatches and latches the first failure.
module dpram_bist_checker
    import dpram_bist_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              fin,
    input  logic              cmp_en,
    input  logic              cmp_port,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_port,
    output logic              pass
);

    logic              en_q;
    logic              port_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] actual;
    logic              mismatch;
    logic              first_fail;
    logic [7:0]        err_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b0;
            port_q <= 1'b0;
            addr_q <= '0;
            exp_q  <= '0;
        end else begin
            en_q   <= cmp_en;
            port_q <= cmp_port;
            addr_q <= cmp_addr;
            exp_q  <= cmp_exp;
        end
    end

    always_comb begin
        actual     = port_q ? q_b : q_a;
        mismatch   = en_q && (actual != exp_q);
        first_fail = mismatch && (err_count == '0);
        err_nxt    = err_count;
        if (mismatch && (err_count < 8'(ERR_MAX)))
            err_nxt = err_count + 8'd1;
    end

    // pass folds in the compare landing on the same edge as the DONE update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            pass      <= 1'b0;
        end else if (clr) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            pass      <= 1'b0;
        end else begin
            err_count <= err_nxt;
            if (first_fail) begin
                fail_addr <= addr_q;
                fail_port <= port_q;
            end
            if (fin)
                pass <= (err_nxt == '0);
        end
    end

endmodule

// File: rtl/dpram_bist.sv
// Dual-port RAM BIST: write pattern via A, read it back via B while A writes
// the inverse behind it, then read the inverse back via A.
module dpram_bist
    import dpram_bist_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              we_a,
    output logic              we_b,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_port
);

    localparam int unsigned WR_LEN = (ADDR_W == ADDR_W_DEF) ? WR_A_LEN : wr_len(ADDR_W);
    localparam int unsigned RB_LEN = (ADDR_W == ADDR_W_DEF) ? RD_B_LEN : rd_len(ADDR_W);
    localparam int unsigned RA_LEN = (ADDR_W == ADDR_W_DEF) ? RD_A_LEN : rd_len(ADDR_W);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   k, k_nxt;
    logic [DATA_W-1:0] seed_reg, seed_nxt;
    logic [ADDR_W-1:0] kaddr, kprev;

    logic [DATA_W-1:0] data_a_n, data_b_n;
    logic [ADDR_W-1:0] addr_a_n, addr_b_n;
    logic              we_a_n, we_b_n, busy_n, done_n;

    logic              clr, fin;
    logic              cmp_en, cmp_port;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_exp;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return seed_reg ^ DATA_W'(a);
    endfunction

    assign kaddr = k[ADDR_W-1:0];
    assign kprev = kaddr - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            k        <= '0;
            seed_reg <= '0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            seed_reg <= seed_nxt;
        end
    end

    // RAM-side and status outputs are registered copies of what this decode
    // produces, so every phase appears on the pins one clock after its state.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        seed_nxt  = seed_reg;
        data_a_n  = '0;
        data_b_n  = '0;
        addr_a_n  = '0;
        addr_b_n  = '0;
        we_a_n    = 1'b0;
        we_b_n    = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        clr       = 1'b0;
        fin       = 1'b0;
        cmp_en    = 1'b0;
        cmp_port  = 1'b0;
        cmp_addr  = '0;
        cmp_exp   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WR_A;
                    k_nxt     = '0;
                    seed_nxt  = seed;
                    clr       = 1'b1;
                    busy_n    = 1'b1;
                end
            end
            ST_WR_A: begin
                busy_n   = 1'b1;
                addr_a_n = kaddr;
                data_a_n = pat(kaddr);
                we_a_n   = 1'b1;
                addr_b_n = ~kaddr;
                if (32'(k) == WR_LEN - 1) begin
                    state_nxt = ST_RD_B;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            ST_RD_B: begin
                busy_n = 1'b1;
                if (!k[ADDR_W])
                    addr_b_n = kaddr;
                // Port A trails port B by one word, so it never writes the word B reads.
                if (k != '0) begin
                    addr_a_n = kprev;
                    data_a_n = ~pat(kprev);
                    we_a_n   = 1'b1;
                    cmp_en   = 1'b1;
                    cmp_port = 1'b1;
                    cmp_addr = kprev;
                    cmp_exp  = pat(kprev);
                end
                if (32'(k) == RB_LEN - 1) begin
                    state_nxt = ST_RD_A;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            ST_RD_A: begin
                busy_n = 1'b1;
                if (!k[ADDR_W])
                    addr_a_n = kaddr;
                if (k != '0) begin
                    cmp_en   = 1'b1;
                    cmp_port = 1'b0;
                    cmp_addr = kprev;
                    cmp_exp  = ~pat(kprev);
                end
                if (32'(k) == RA_LEN - 1) begin
                    state_nxt = ST_DONE;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            ST_DONE: begin
                done_n    = 1'b1;
                fin       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                k_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_a <= '0;
            data_b <= '0;
            addr_a <= '0;
            addr_b <= '0;
            we_a   <= 1'b0;
            we_b   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            data_a <= data_a_n;
            data_b <= data_b_n;
            addr_a <= addr_a_n;
            addr_b <= addr_b_n;
            we_a   <= we_a_n;
            we_b   <= we_b_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    dpram_bist_checker #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .fin      (fin),
        .cmp_en   (cmp_en),
        .cmp_port (cmp_port),
        .cmp_addr (cmp_addr),
        .cmp_exp  (cmp_exp),
        .q_a      (q_a),
        .q_b      (q_b),
        .err_count(err_count),
        .fail_addr(fail_addr),
        .fail_port(fail_port),
        .pass     (pass)
    );

endmodule

// File: tb/tb_dpram_bist.sv
// Bench for dpram_bist: dual-port RAM model with optional stuck bit,
// table of runs with expected status from a whole-run reference model.
module tb_dpram_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic [7:0] data_a, data_b, q_a, q_b;
    logic [5:0] addr_a, addr_b;
    logic       we_a, we_b, busy, done, pass, fail_port;
    logic [7:0] err_count;
    logic [5:0] fail_addr;

    int errors = 0;
    int checks = 0;
    int conflicts = 0;

    bit         fault_en = 1'b0;
    int         fault_addr = 0;
    int         fault_bit = 0;
    bit         stuck_val = 1'b0;
    logic [7:0] mem [64];

    always #5 clk = ~clk;

    dpram_bist #(
        .DATA_W(8),
        .ADDR_W(6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed     (seed),
        .data_a   (data_a),
        .data_b   (data_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .we_a     (we_a),
        .we_b     (we_b),
        .q_a      (q_a),
        .q_b      (q_b),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_addr(fail_addr),
        .fail_port(fail_port)
    );

    function automatic logic [7:0] ram_read(input logic [5:0] a);
        logic [7:0] v;
        v = mem[a];
        if (fault_en && int'(a) == fault_addr)
            v[fault_bit] = stuck_val;
        return v;
    endfunction

    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        q_a <= ram_read(addr_a);
        q_b <= ram_read(addr_b);
    end

    always @(negedge clk)
        if ((we_a || we_b) && addr_a == addr_b)
            conflicts++;

    typedef struct {
        logic [7:0] seed;
        bit         fe;
        int         fa;
        int         fb;
        bit         sv;
        int         retrig;
        int         exp_err;
        int         exp_faddr;
        bit         exp_fport;
        bit         exp_pass;
    } vec_t;

    typedef struct {
        int err;
        int faddr;
        bit fport;
    } res_t;

    // Whole-run outcome: pattern read via B, then inverse read via A, in address order.
    function automatic res_t ref_run(input logic [7:0] s, input bit fe, input int fa,
                                     input int fb, input bit sv);
        res_t r;
        logic [7:0] expv, rd;
        r.err = 0; r.faddr = 0; r.fport = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < 64; a++) begin
                expv = s ^ 8'(a);
                if (ph == 1) expv = ~expv;
                rd = expv;
                if (fe && a == fa) rd[fb] = sv;
                if (rd != expv) begin
                    if (r.err == 0) begin
                        r.faddr = a;
                        r.fport = (ph == 0);
                    end
                    if (r.err < 128) r.err++;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, done_cnt, done_cyc, busy_bad, wr_cnt, wr_bad, ram_bad, pass_at_done;
        fault_en = v.fe; fault_addr = v.fa; fault_bit = v.fb; stuck_val = v.sv;
        @(negedge clk);
        seed = v.seed;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seed = ~v.seed;
        cyc = 0; done_cnt = 0; done_cyc = -1; busy_bad = 0;
        wr_cnt = 0; wr_bad = 0; pass_at_done = -1;
        while (cyc < 400 && !(done_cyc >= 0 && cyc >= done_cyc + 4)) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    pass_at_done = int'(pass);
                end
            end
            if (busy != (done_cyc < 0)) busy_bad++;
            if (we_a && wr_cnt < 64) begin
                if (int'(addr_a) != wr_cnt || data_a != (v.seed ^ 8'(wr_cnt))) wr_bad++;
                wr_cnt++;
            end
            if (v.retrig != 0) start = (cyc == v.retrig);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        ram_bad = 0;
        for (int a = 0; a < 64; a++)
            if (mem[a] !== ~(v.seed ^ 8'(a))) ram_bad++;
        check({tag, ".done_cycle"}, done_cyc, 195);
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".busy_bad_cycles"}, busy_bad, 0);
        check({tag, ".wr_a_count"}, wr_cnt, 64);
        check({tag, ".wr_a_bad"}, wr_bad, 0);
        check({tag, ".pass_at_done"}, pass_at_done, int'(v.exp_pass));
        check({tag, ".err_count"}, int'(err_count), v.exp_err);
        check({tag, ".fail_addr"}, int'(fail_addr), v.exp_faddr);
        check({tag, ".fail_port"}, int'(fail_port), int'(v.exp_fport));
        check({tag, ".pass_hold"}, int'(pass), int'(v.exp_pass));
        check({tag, ".ram_inverse_bad"}, ram_bad, 0);
        check({tag, ".idle_outputs"}, int'({we_a, we_b, busy, addr_a, addr_b, data_a}), 0);
    endtask

    vec_t vecs[10];
    res_t rr;
    vec_t rv;

    initial begin
        vecs[0] = '{8'h00, 1'b0, 0, 0, 1'b0, 0,   0, 0, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 1'b0, 0, 0, 1'b0, 0,   0, 0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 5, 0, 1'b0, 0,   1, 5, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 0, 0, 1'b0, 100, 0, 0, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, 1'b0, 0, 0, 1'b0, 194, 0, 0, 1'b0, 1'b1};
        for (int i = 5; i < 10; i++) begin
            vecs[i].seed   = 8'($urandom);
            vecs[i].fe     = (i != 9);
            vecs[i].fa     = int'($urandom_range(0, 63));
            vecs[i].fb     = int'($urandom_range(0, 7));
            vecs[i].sv     = 1'($urandom);
            vecs[i].retrig = 0;
            rr = ref_run(vecs[i].seed, vecs[i].fe, vecs[i].fa, vecs[i].fb, vecs[i].sv);
            vecs[i].exp_err   = rr.err;
            vecs[i].exp_faddr = rr.faddr;
            vecs[i].exp_fport = rr.fport;
            vecs[i].exp_pass  = (rr.err == 0);
        end

        rst = 1'b0; start = 1'b0; seed = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({we_a, we_b, busy, done, pass, fail_port, addr_a, addr_b}), 0);
        check("reset_status", int'({err_count, fail_addr, data_a, data_b}), 0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of RD_B, while port A is writing the inverse.
        fault_en = 1'b0;
        @(negedge clk);
        seed = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_run.we_a_before_reset", int'(we_a), 1);
        check("mid_run.busy_before_reset", int'(busy), 1);
        #1 rst = 1'b0;
        #1;
        check("mid_run.reset_we", int'({we_a, we_b}), 0);
        check("mid_run.reset_busy_done", int'({busy, done}), 0);
        check("mid_run.reset_rest",
              int'({addr_a, addr_b, data_a, err_count, pass, fail_port}), 0);
        @(negedge clk);
        rst = 1'b1;
        rr = ref_run(8'h3C, 1'b0, 0, 0, 1'b0);
        rv = '{8'h3C, 1'b0, 0, 0, 1'b0, 0, rr.err, rr.faddr, rr.fport, rr.err == 0};
        run_vec(rv, "after_reset");

        check("port_conflicts", conflicts, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
